// File: rtl/bcsa_eru_seq.sv
// Handshaked block-carry-speculative adder with error-reduction unit and optional correction cycle.
// Optional feature: define BCSA_ERU_ERRCNT_EN to build the saturating error counter (err_cnt_o, cnt_clr_i).
module bcsa_eru_seq #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             exact_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   sum_o,
  output logic             err_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int NBLK = WIDTH / BLK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_FIX,
    S_OUT
  } state_e;

  // Sum-of-products carry lookahead: every carry depends only on g, p and cin.
  function automatic logic [BLK:0] cla_add(input logic [BLK-1:0] x,
                                           input logic [BLK-1:0] y,
                                           input logic           cin);
    logic [BLK-1:0] gp;
    logic [BLK-1:0] pp;
    logic [BLK:0]   c;
    logic           term_p;
    gp     = x & y;
    pp     = x ^ y;
    c      = '0;
    c[0]   = cin;
    term_p = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = 1'b0;
      term_p = 1'b1;
      for (int k = i; k >= 0; k--) begin
        c[i+1] = c[i+1] | (gp[k] & term_p);
        term_p = term_p & pp[k];
      end
      c[i+1] = c[i+1] | (cin & term_p);
    end
    return {c[BLK], pp ^ c[BLK-1:0]};
  endfunction

  function automatic logic [WIDTH:0] bcsa_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   res;
    logic [BLK:0]     blk_r;
    logic [BLK:0]     prev_r;
    logic             cadd;
    logic             sel;
    logic             cj;
    logic             carry;
    p      = x ^ y;
    g      = x & y;
    res    = '0;
    blk_r  = cla_add(x[BLK-1:0], y[BLK-1:0], 1'b0);
    res[BLK-1:0] = blk_r[BLK-1:0];
    carry  = blk_r[BLK];
    prev_r = blk_r;
    for (int j = 1; j < NBLK; j++) begin
      // Local carry of the block below with cin = 0, not the rippled one.
      prev_r = cla_add(x[(j-1)*BLK +: BLK], y[(j-1)*BLK +: BLK], 1'b0);
      cadd   = prev_r[BLK];
      sel    = g[j*BLK-1] | (~x[j*BLK] & ~y[j*BLK]);
      cj     = sel ? g[j*BLK-1] : cadd;
      blk_r  = cla_add(x[j*BLK +: BLK], y[j*BLK +: BLK], cj);
      res[j*BLK +: BLK] = blk_r[BLK-1:0];
      res[j*BLK] = (p[j*BLK] ^ cj) | (~p[j*BLK] & ~g[j*BLK] & cadd);
      carry  = blk_r[BLK];
    end
    res[WIDTH] = carry;
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             exact_q, exact_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   approx_w;
  logic [WIDTH:0]   exact_w;
  logic             spec_err_w;
  logic             cnt_inc_w;

  assign approx_w   = bcsa_add(a_q, b_q);
  assign exact_w    = {1'b0, a_q} + {1'b0, b_q};
  assign spec_err_w = (approx_w != exact_w);

  assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready_i);
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign err_o       = err_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    exact_d     = exact_q;
    sum_d       = sum_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    cnt_inc_w   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          exact_d = exact_mode_i;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        cnt_inc_w = spec_err_w;
        if (spec_err_w && exact_q) begin
          state_d = S_FIX;
        end else begin
          sum_d       = approx_w;
          err_d       = spec_err_w;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_FIX: begin
        sum_d       = exact_w;
        err_d       = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (in_valid_i) begin
            a_d     = a_i;
            b_d     = b_i;
            exact_d = exact_mode_i;
            state_d = S_EVAL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      exact_q     <= 1'b0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exact_q     <= exact_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BCSA_ERU_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (cnt_inc_w && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = cnt_clr_i | cnt_inc_w;
  assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_bcsa_eru_seq.sv
// Directed self-checking bench for bcsa_eru_seq (WIDTH=32, BLK=8, CNT_W=2 so saturation is reachable).
module tb_bcsa_eru_seq;

  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int CNT_W = 2;
`ifdef BCSA_ERU_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             exact_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             err;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bcsa_eru_seq #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_i          (a),
    .b_i          (b),
    .exact_mode_i (exact_mode),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .sum_o        (sum),
    .err_o        (err),
    .cnt_clr_i    (cnt_clr),
    .err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counter value the build should show: the counter reads 0 when compiled out.
  function automatic logic [63:0] ecnt(input int v);
    return CNT_EN ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = active edges after the accept edge until out_valid is seen (1 plain, 2 with FIX).
  task automatic do_beat(input logic [31:0] av, input logic [31:0] bv, input logic em,
                         input logic [32:0] es, input logic ee, input int el,
                         input int cnt, input logic clr, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "/in_ready"}, in_ready, 1);
    a          = av;
    b          = bv;
    exact_mode = em;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_clr  = clr;
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      cnt_clr = 1'b0;
      n++;
    end
    cnt_clr = 1'b0;
    check({tag, "/lat"}, n, el);
    check({tag, "/sum"}, sum, es);
    check({tag, "/err"}, err, ee);
    check({tag, "/err_cnt"}, err_cnt, ecnt(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    cnt_clr    = 1'b0;
    a          = '0;
    b          = '0;
    exact_mode = 1'b0;
    #2;
    check("rst/out_valid", out_valid, 0);
    check("rst/sum", sum, 0);
    check("rst/err", err, 0);
    check("rst/err_cnt", err_cnt, 0);
    check("rst/in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    do_beat(32'h0000FF80, 32'h00000080, 1'b0, 33'h000000000, 1'b1, 1, 1, 1'b0, "spec_err_approx");
    do_beat(32'h0000FF80, 32'h00000080, 1'b1, 33'h000010000, 1'b1, 2, 2, 1'b0, "spec_err_fix");
    do_beat(32'h000000FF, 32'h00000001, 1'b0, 33'h000000100, 1'b0, 1, 2, 1'b0, "eru_lsb_approx");
    do_beat(32'h000000FF, 32'h00000001, 1'b1, 33'h000000100, 1'b0, 1, 2, 1'b0, "eru_lsb_exact");
    do_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1FFFFFFFE, 1'b0, 1, 2, 1'b0, "all_ones");
    do_beat(32'h01020304, 32'h10203040, 1'b0, 33'h011223344, 1'b0, 1, 2, 1'b0, "no_carry");
    do_beat(32'hFF800000, 32'h00800000, 1'b0, 33'h100000000, 1'b0, 1, 2, 1'b0, "top_carry");

    // Backpressure: drain to IDLE first, then hold the result for five cycles.
    tick();
    out_ready = 1'b0;
    do_beat(32'h0000FF80, 32'h00000080, 1'b0, 33'h000000000, 1'b1, 1, 3, 1'b0, "bp_beat");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp/out_valid", out_valid, 1);
      check("bp/sum", sum, 33'h000000000);
      check("bp/err", err, 1);
      check("bp/in_ready", in_ready, 0);
    end
    a          = 32'h000000FF;
    b          = 32'h00000001;
    exact_mode = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("b2b/in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b/captured", out_valid, 0);
    tick();
    check("b2b/out_valid", out_valid, 1);
    check("b2b/sum", sum, 33'h000000100);
    check("b2b/err", err, 0);

    do_beat(32'h0000FF80, 32'h00000080, 1'b0, 33'h000000000, 1'b1, 1, 3, 1'b0, "saturate");
    do_beat(32'h0000FF80, 32'h00000080, 1'b0, 33'h000000000, 1'b1, 1, 0, 1'b1, "clr_vs_inc");
    do_beat(32'h0000FF80, 32'h00000080, 1'b1, 33'h000010000, 1'b1, 2, 1, 1'b0, "count_resume");

    // Reset while the correction cycle is in flight.
    a          = 32'h0000FF80;
    b          = 32'h00000080;
    exact_mode = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rfix/eval_in_ready", in_ready, 0);
    tick();
    check("rfix/fix_in_ready", in_ready, 0);
    check("rfix/fix_out_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("rfix/out_valid", out_valid, 0);
    check("rfix/in_ready", in_ready, 1);
    check("rfix/err_cnt", err_cnt, 0);
    check("rfix/sum", sum, 0);
    check("rfix/err", err, 0);
    tick();
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        seen = seen | out_valid;
      end
      check("rfix/no_output", seen, 0);
    end
    do_beat(32'h01020304, 32'h10203040, 1'b0, 33'h011223344, 1'b0, 1, 0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
